// File: rtl/int_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} int_state_t;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder; valid is high when any request is set.
module int_prio_enc
  import int_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  localparam int ID_W    = id_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan downward so the last hit, the lowest index, is the one kept.
  always_comb begin
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) id = ID_W'(i);
  end

  assign valid = |req;

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge-detected pending latches, mask, fixed priority, EPC/eret.
// Define INT_SYNC_EN to put a 2-flop synchroniser in front of the edge detector.
module vec_int_ctrl
  import int_pkg::*;
#(
  parameter  int                NUM_IRQ    = 4,
  parameter  int                ADDR_W     = 32,
  parameter  logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter  logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE),
  localparam int                ID_W       = id_w(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  input  logic               hold,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               eret,
  output logic               int_take,
  output logic [ADDR_W-1:0]  int_vec,
  output logic [ID_W-1:0]    int_id,
  output logic [ADDR_W-1:0]  epc,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pend_q,
  output logic [NUM_IRQ-1:0] mask_q,
  output logic               gie_q
);

  logic [NUM_IRQ-1:0] irq_src, irq_prev, rise, elig, clr;
  logic [ID_W-1:0]    sel;
  logic               sel_vld;
  int_state_t         state, state_nxt;
  logic               take_go, ret_go;

`ifdef INT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_src = sync2;
`else
  assign irq_src = irq_in;
`endif

  assign rise = irq_src & ~irq_prev;
  assign elig = pend_q & mask_q;

  int_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req   (elig),
    .id    (sel),
    .valid (sel_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_go   = 1'b0;
    ret_go    = 1'b0;
    case (state)
      IDLE: if (gie_q && sel_vld && !hold) begin
        take_go   = 1'b1;
        state_nxt = TAKE;
      end
      TAKE: state_nxt = SERVICE;
      SERVICE: if (eret) begin
        ret_go    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr = take_go ? (NUM_IRQ'(1) << sel) : '0;

  // A fresh edge on the source being cleared survives: set is OR'd after the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev   <= '0;
      pend_q     <= '0;
      mask_q     <= '1;
      gie_q      <= 1'b1;
      int_id     <= '0;
      epc        <= '0;
      in_service <= 1'b0;
    end else begin
      irq_prev <= irq_src;
      pend_q   <= (pend_q & ~clr) | rise;
      if (mask_we) mask_q <= mask_wd;
      if (take_go) begin
        int_id <= sel;
        epc    <= pc_next;
        gie_q  <= 1'b0;
      end
      if (state == TAKE) in_service <= 1'b1;
      if (ret_go) begin
        in_service <= 1'b0;
        gie_q      <= 1'b1;
      end
    end
  end

  assign int_take = (state == TAKE);
  assign int_vec  = VEC_BASE + ADDR_W'(int_id) * VEC_STRIDE;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Scenario bench for vec_int_ctrl; expected takes are queued and matched on each int_take.
module tb_vec_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wd;
  logic        hold;
  logic [31:0] pc_next;
  logic        eret;
  logic        int_take;
  logic [31:0] int_vec;
  logic [1:0]  int_id;
  logic [31:0] epc;
  logic        in_service;
  logic [3:0]  pend_q;
  logic [3:0]  mask_q;
  logic        gie_q;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vec;
    logic [31:0] epc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vec_int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wd(mask_wd),
    .hold(hold), .pc_next(pc_next), .eret(eret), .int_take(int_take), .int_vec(int_vec),
    .int_id(int_id), .epc(epc), .in_service(in_service), .pend_q(pend_q), .mask_q(mask_q),
    .gie_q(gie_q)
  );

  // Scoreboard: every take must match the oldest expected take.
  always @(negedge clk) begin
    if (int_take) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_take got id=%0d vec=%h", int_id, int_vec);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int_id !== e.id || int_vec !== e.vec || epc !== e.epc)
          $display("FAIL sb_take got id=%0d vec=%h epc=%h exp id=%0d vec=%h epc=%h",
                   int_id, int_vec, epc, e.id, e.vec, e.epc);
        else passes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_take(input logic [1:0] id, input logic [31:0] pc);
    exp_t e;
    e.id  = id;
    e.vec = 32'h100 + 32'(id) * 32'h10;
    e.epc = pc;
    sb.push_back(e);
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wd = '0; hold = 1'b0;
    pc_next = '0; eret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0 || pend_q !== 4'h0 || int_id !== 2'd0 || epc !== 32'h0)
      $display("FAIL reset_outs got take=%b insvc=%b pend=%h id=%0d epc=%h exp 0", int_take, in_service, pend_q, int_id, epc);
    else passes++;
    checks++;
    if (mask_q !== 4'hF || gie_q !== 1'b1)
      $display("FAIL reset_mask_gie got mask=%h gie=%b exp F 1", mask_q, gie_q);
    else passes++;
  endtask

  task automatic test_single();
    pc_next = 32'h40;
    irq_in  = 4'b0100;
    expect_take(2'd2, 32'h40);
    tick();
    checks++;
    if (pend_q !== 4'b0100 || int_take !== 1'b0)
      $display("FAIL single_pend got pend=%b take=%b exp 0100 0", pend_q, int_take);
    else passes++;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd2 || int_vec !== 32'h120 || epc !== 32'h40 ||
        pend_q !== 4'h0 || gie_q !== 1'b0 || in_service !== 1'b0)
      $display("FAIL single_take got take=%b id=%0d vec=%h epc=%h pend=%b gie=%b insvc=%b",
               int_take, int_id, int_vec, epc, pend_q, gie_q, in_service);
    else passes++;
    tick();
    irq_in = '0;
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b1)
      $display("FAIL single_service got take=%b insvc=%b exp 0 1", int_take, in_service);
    else passes++;
    do_eret();
    checks++;
    if (in_service !== 1'b0 || gie_q !== 1'b1)
      $display("FAIL single_eret got insvc=%b gie=%b exp 0 1", in_service, gie_q);
    else passes++;
  endtask

  task automatic test_simul();
    pc_next = 32'h200;
    irq_in  = 4'b1010;
    expect_take(2'd1, 32'h200);
    tick(); tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd1 || pend_q !== 4'b1000)
      $display("FAIL simul_first got take=%b id=%0d pend=%b exp 1 1 1000", int_take, int_id, pend_q);
    else passes++;
    tick();
    irq_in = '0;
    repeat (4) tick();
    checks++;
    if (pend_q !== 4'b1000 || in_service !== 1'b1)
      $display("FAIL simul_hold_off got pend=%b insvc=%b exp 1000 1", pend_q, in_service);
    else passes++;
    pc_next = 32'h300;
    expect_take(2'd3, 32'h300);
    do_eret();
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0)
      $display("FAIL simul_idle got take=%b insvc=%b exp 0 0", int_take, in_service);
    else passes++;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd3 || int_vec !== 32'h130)
      $display("FAIL simul_second got take=%b id=%0d vec=%h exp 1 3 130", int_take, int_id, int_vec);
    else passes++;
    tick();
    do_eret();
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wd = 4'b1110;
    tick();
    mask_we = 1'b0;
    irq_in  = 4'b0001;
    tick();
    irq_in = '0;
    repeat (10) tick();
    checks++;
    if (mask_q !== 4'b1110 || pend_q !== 4'b0001 || in_service !== 1'b0 || gie_q !== 1'b1)
      $display("FAIL mask_blocked got mask=%b pend=%b insvc=%b gie=%b", mask_q, pend_q, in_service, gie_q);
    else passes++;
    pc_next = 32'h500;
    expect_take(2'd0, 32'h500);
    mask_we = 1'b1; mask_wd = 4'b1111;
    tick();
    mask_we = 1'b0;
    checks++;
    if (int_take !== 1'b0 || mask_q !== 4'hF)
      $display("FAIL mask_write got take=%b mask=%h exp 0 F", int_take, mask_q);
    else passes++;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd0 || int_vec !== 32'h100)
      $display("FAIL mask_take got take=%b id=%0d vec=%h exp 1 0 100", int_take, int_id, int_vec);
    else passes++;
    tick();
    do_eret();
  endtask

  task automatic test_set_wins();
    // hold delays the take so irq2 can produce a second edge on the clearing edge
    hold    = 1'b1;
    pc_next = 32'h600;
    irq_in  = 4'b0100;
    tick();
    irq_in = '0;
    tick();
    hold   = 1'b0;
    irq_in = 4'b0100;
    expect_take(2'd2, 32'h600);
    tick();
    irq_in = '0;
    checks++;
    if (int_take !== 1'b1 || pend_q !== 4'b0100)
      $display("FAIL set_wins got take=%b pend=%b exp 1 0100", int_take, pend_q);
    else passes++;
    tick();
    pc_next = 32'h700;
    expect_take(2'd2, 32'h700);
    do_eret();
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd2 || pend_q !== 4'h0)
      $display("FAIL set_wins_retake got take=%b id=%0d pend=%b exp 1 2 0", int_take, int_id, pend_q);
    else passes++;
    tick();
    do_eret();
    do_eret();
    checks++;
    if (int_take !== 1'b0 || in_service !== 1'b0 || gie_q !== 1'b1 || pend_q !== 4'h0)
      $display("FAIL eret_idle got take=%b insvc=%b gie=%b pend=%b", int_take, in_service, gie_q, pend_q);
    else passes++;
  endtask

  task automatic test_hold_reset();
    hold    = 1'b1;
    pc_next = 32'h800;
    irq_in  = 4'b1000;
    tick();
    irq_in = '0;
    repeat (4) tick();
    checks++;
    if (int_take !== 1'b0 || pend_q !== 4'b1000 || in_service !== 1'b0)
      $display("FAIL hold_block got take=%b pend=%b insvc=%b", int_take, pend_q, in_service);
    else passes++;
    expect_take(2'd3, 32'h800);
    hold = 1'b0;
    tick();
    checks++;
    if (int_take !== 1'b1 || int_id !== 2'd3)
      $display("FAIL hold_release got take=%b id=%0d exp 1 3", int_take, int_id);
    else passes++;
    hold = 1'b1;
    tick();
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    checks++;
    if (in_service !== 1'b1 || pend_q !== 4'b0001)
      $display("FAIL hold_in_service got insvc=%b pend=%b exp 1 0001", in_service, pend_q);
    else passes++;
    hold = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (in_service !== 1'b0 || gie_q !== 1'b1 || pend_q !== 4'h0 || int_take !== 1'b0 ||
        epc !== 32'h0 || int_id !== 2'd0 || mask_q !== 4'hF)
      $display("FAIL async_reset got insvc=%b gie=%b pend=%b take=%b epc=%h id=%0d mask=%h",
               in_service, gie_q, pend_q, int_take, epc, int_id, mask_q);
    else passes++;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_mask();
    test_set_wins();
    test_hold_reset();
    checks++;
    if (sb.size() !== 0)
      $display("FAIL sb_drain got %0d pending takes exp 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
